maze_map_streamer: RTL

//   Read-side companion to the 1-bit maze bitmap memory. On start, scans the whole

---
 rtl/maze_map_streamer.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/maze_map_streamer.sv
// maze_map_streamer
//   Read-side companion to the 1-bit maze bitmap memory. A start request makes
//   the block scan the whole WIDTH x HEIGHT bitmap, one bit per cycle, over the
//   memory read port. Each row is packed into a WIDTH-bit word (bit x = mem[x][y])
//   and handed to a row consumer over a valid/ready stream.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   start, abort          begin a scan (idle only) / cancel a running scan
//   mem_rd, mem_addr_x/y  memory read request; the address holds when not reading
//   mem_data              combinational read data from the bitmap memory
//   row_data, row_y       packed row word and its row index
//   row_valid, row_ready  stream handshake; row_last marks row HEIGHT-1
//   busy, done            scan in progress / one-cycle pulse after the final row

module maze_map_streamer #(
    parameter int WIDTH  = 16,
    parameter int HEIGHT = 16,
    parameter int ADDR_W = 4,
    parameter int ADDR_H = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr_x,
    output logic [ADDR_H-1:0] mem_addr_y,
    input  logic              mem_data,
    output logic [WIDTH-1:0]  row_data,
    output logic [ADDR_H-1:0] row_y,
    output logic              row_valid,
    input  logic              row_ready,
    output logic              row_last,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LAST_X = ADDR_W'(WIDTH - 1);
    localparam logic [ADDR_H-1:0] LAST_Y = ADDR_H'(HEIGHT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic [ADDR_W-1:0] x;
    logic [ADDR_H-1:0] y;
    logic [ADDR_W-1:0] hold_x;
    logic [ADDR_H-1:0] hold_y;
    logic [WIDTH-1:0]  row_word;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. Abort only matters once a scan is running, so a start
    // and an abort arriving together in IDLE still launch a scan.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = FILL;
                end
            end
            FILL: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (x == LAST_X) begin
                    state_next = SEND;
                end
            end
            SEND: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (row_ready) begin
                    state_next = (y == LAST_Y) ? DONE : FILL;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Scan counters and the row word being assembled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x        <= '0;
            y        <= '0;
            row_word <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        x        <= '0;
                        y        <= '0;
                        row_word <= '0;
                    end
                end
                FILL: begin
                    if (abort) begin
                        x <= '0;
                        y <= '0;
                    end else begin
                        row_word[x] <= mem_data;
                        x           <= (x == LAST_X) ? '0 : x + ADDR_W'(1);
                    end
                end
                SEND: begin
                    if (abort) begin
                        x <= '0;
                        y <= '0;
                    end else if (row_ready && (y != LAST_Y)) begin
                        y <= y + ADDR_H'(1);
                    end
                end
                DONE: begin
                    if (abort) begin
                        x <= '0;
                        y <= '0;
                    end
                end
                default: begin
                    x <= '0;
                    y <= '0;
                end
            endcase
        end
    end

    // Remember the last address driven during FILL so the memory port keeps a
    // steady address while the block is not reading.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_x <= '0;
            hold_y <= '0;
        end else if (state == FILL) begin
            hold_x <= x;
            hold_y <= y;
        end
    end

    // Output decode. Everything except the row word and index follows the
    // state directly, so an asynchronous reset clears them at once.
    always_comb begin
        mem_rd     = (state == FILL);
        mem_addr_x = (state == FILL) ? x : hold_x;
        mem_addr_y = (state == FILL) ? y : hold_y;
        row_valid  = (state == SEND);
        row_last   = (state == SEND) && (y == LAST_Y);
        busy       = (state != IDLE);
        done       = (state == DONE);
        row_data   = row_word;
        row_y      = y;
    end

endmodule
